// File: rtl/axi_full_burst_tester.sv
// rtl/axi_full_burst_tester.sv - AXI4-full master: writes NUM_BURSTS INCR bursts of seed+k, reads them back, counts errors
module axi_full_burst_tester #(
    parameter logic [63:0] C_M_TARGET_BASE_ADDR = 64'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH   = 32,
    parameter int          C_M_AXI_DATA_WIDTH   = 32,
    parameter int          C_M_AXI_ID_WIDTH     = 1,
    parameter int          C_M_BURST_LEN        = 16,
    parameter int          C_M_NUM_BURSTS       = 4,
    parameter int          C_ERR_CNT_WIDTH      = 8
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
    output logic                            busy,
    output logic                            done,
    output logic                            err_flag,
    output logic [C_ERR_CNT_WIDTH-1:0]      err_count,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int DW          = C_M_AXI_DATA_WIDTH;
    localparam int BYTES       = DW / 8;
    localparam int BURST_BYTES = C_M_BURST_LEN * BYTES;
    localparam int BEAT_W      = (C_M_BURST_LEN > 1) ? $clog2(C_M_BURST_LEN) : 1;
    localparam int B_W         = (C_M_NUM_BURSTS > 1) ? $clog2(C_M_NUM_BURSTS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_M_BURST_LEN - 1);
    localparam logic [B_W-1:0]    LAST_B    = B_W'(C_M_NUM_BURSTS - 1);
    localparam logic [7:0]        AXLEN     = 8'(C_M_BURST_LEN - 1);
    localparam logic [2:0]        AXSIZE    = 3'($clog2(BYTES));

    generate
        if (C_M_BURST_LEN < 1 || C_M_BURST_LEN > 256 || BURST_BYTES > 4096 ||
            (BURST_BYTES & (BURST_BYTES - 1)) != 0 || C_M_NUM_BURSTS < 1 ||
            !(DW == 32 || DW == 64 || DW == 128)) begin : g_bad_cfg
            $error("axi_full_burst_tester: illegal width/burst configuration");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [B_W-1:0]         b_q, b_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [DW-1:0]          seed_q, seed_d;
    logic                   done_q, done_d;
    logic [C_ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                   err_inc;
    logic                   last_beat, last_burst;
    logic [DW-1:0]          exp_word;
    logic [AW-1:0]          burst_addr;

    // Word k = b*BURST_LEN + beat; the same value drives WDATA and is the read-back reference.
    assign exp_word   = seed_q + DW'(b_q) * DW'(C_M_BURST_LEN) + DW'(beat_q);
    assign burst_addr = AW'(C_M_TARGET_BASE_ADDR) + AW'(b_q) * AW'(BURST_BYTES);
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (b_q == LAST_B);

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        beat_d      = beat_q;
        seed_d      = seed_q;
        done_d      = done_q;
        err_count_d = err_count_q;
        err_inc     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    seed_d      = seed;
                    done_d      = 1'b0;
                    err_count_d = '0;
                    b_d         = '0;
                    beat_d      = '0;
                    state_d     = S_WA;
                end
            end
            S_WA: if (M_AXI_AWREADY) begin
                beat_d  = '0;
                state_d = S_WD;
            end
            S_WD: if (M_AXI_WREADY) begin
                if (last_beat) begin
                    beat_d  = '0;
                    state_d = S_WB;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WB: if (M_AXI_BVALID) begin
                err_inc = (M_AXI_BRESP != 2'b00);
                if (last_burst) begin
                    b_d     = '0;
                    state_d = S_RA;
                end else begin
                    b_d     = b_q + 1'b1;
                    state_d = S_WA;
                end
            end
            S_RA: if (M_AXI_ARREADY) begin
                beat_d  = '0;
                state_d = S_RD;
            end
            S_RD: if (M_AXI_RVALID) begin
                // Several faults on one beat still count as a single error.
                err_inc = (M_AXI_RDATA != exp_word) || (M_AXI_RRESP != 2'b00) ||
                          (M_AXI_RLAST != last_beat);
                if (M_AXI_RLAST || last_beat) begin
                    beat_d = '0;
                    if (last_burst) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        b_d     = b_q + 1'b1;
                        state_d = S_RA;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            beat_q      <= '0;
            seed_q      <= '0;
            done_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            beat_q      <= beat_d;
            seed_q      <= seed_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = done_q;
    assign err_count = err_count_q;
    assign err_flag  = (err_count_q != '0);

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = burst_addr;
    assign M_AXI_AWLEN   = AXLEN;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = (state_q == S_WA);
    assign M_AXI_WDATA   = exp_word;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state_q == S_WD) && last_beat;
    assign M_AXI_WVALID  = (state_q == S_WD);
    assign M_AXI_BREADY  = (state_q == S_WB);
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = burst_addr;
    assign M_AXI_ARLEN   = AXLEN;
    assign M_AXI_ARSIZE  = AXSIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = (state_q == S_RA);
    assign M_AXI_RREADY  = (state_q == S_RD);

    logic unused_ids;
    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

endmodule
